// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch path.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

  localparam int          INSTR_WIDTH      = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          PC_STEP          = 4;

endpackage

// File: rtl/pc_reg.sv
// Program counter: async reset, word-aligned load with priority over increment.
module pc_reg
  import riscv_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  output logic [WIDTH-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val & ~WIDTH'(3);
    end else if (inc) begin
      pc <= pc + WIDTH'(PC_STEP);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one imem read per controller request, IR held until ack.
// state | meaning
// IDLE  | no fetch in flight, waiting for fetch_req
// REQ   | imem_req_valid high at pc, waiting for imem_req_ready
// WAIT  | request accepted, waiting for imem_rsp_valid
// HOLD  | instr/instr_pc/fetch_fault valid until instr_ack
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_req,
  input  logic                   instr_ack,
  input  logic                   pc_load,
  input  logic [WIDTH-1:0]       pc_load_val,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [WIDTH-1:0]       instr_pc,
  output logic                   fetch_fault,
  output logic                   busy,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [WIDTH-1:0]       imem_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  input  logic                   imem_rsp_err
);

  fetch_state_t     state;
  logic [WIDTH-1:0] pc;
  logic             redirect_pend;
  logic [WIDTH-1:0] redirect_pc;
  logic             pc_ld;
  logic [WIDTH-1:0] pc_ld_val;
  logic             pc_inc;
  logic             rsp_take;

  assign rsp_take = (state == ST_WAIT) && imem_rsp_valid;

  // A redirect seen mid-transaction waits for the response, then replaces pc+4.
  always_comb begin
    pc_ld     = 1'b0;
    pc_ld_val = pc_load ? pc_load_val : redirect_pc;
    pc_inc    = 1'b0;
    if ((state == ST_IDLE || state == ST_HOLD) && pc_load) begin
      pc_ld = 1'b1;
    end else if (rsp_take) begin
      pc_ld  = pc_load || redirect_pend;
      pc_inc = !(pc_load || redirect_pend);
    end
  end

  pc_reg #(.WIDTH(WIDTH), .RESET_PC(RESET_PC)) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_ld),
    .load_val (pc_ld_val),
    .inc      (pc_inc),
    .pc       (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      instr         <= '0;
      instr_pc      <= '0;
      fetch_fault   <= 1'b0;
      redirect_pend <= 1'b0;
      redirect_pc   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fetch_req) state <= ST_REQ;
        end
        ST_REQ: begin
          if (pc_load) begin
            redirect_pend <= 1'b1;
            redirect_pc   <= pc_load_val;
          end
          if (imem_req_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            if (pc_load || redirect_pend) begin
              redirect_pend <= 1'b0;
              state         <= ST_REQ;
            end else begin
              instr       <= imem_rsp_err ? '0 : imem_rsp_data;
              instr_pc    <= pc;
              fetch_fault <= imem_rsp_err;
              state       <= ST_HOLD;
            end
          end else if (pc_load) begin
            redirect_pend <= 1'b1;
            redirect_pc   <= pc_load_val;
          end
        end
        ST_HOLD: begin
          if (instr_ack) state <= fetch_req ? ST_REQ : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign instr_valid    = (state == ST_HOLD);
  assign busy           = (state == ST_REQ) || (state == ST_WAIT);
  assign imem_req_valid = (state == ST_REQ);
  assign imem_addr      = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected deliveries queued at response time.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req, instr_ack, pc_load;
  logic [31:0] pc_load_val;
  logic        instr_valid;
  logic [31:0] instr, instr_pc;
  logic        fetch_fault, busy, imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_req      (fetch_req),
    .instr_ack      (instr_ack),
    .pc_load        (pc_load),
    .pc_load_val    (pc_load_val),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .fetch_fault    (fetch_fault),
    .busy           (busy),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Every rising instr_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (instr_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_delivery", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_instr", instr, e.instr);
        chk("sb_instr_pc", instr_pc, e.pc);
        chk("sb_fault", {31'd0, fetch_fault}, {31'd0, e.fault});
      end
    end
    prev_valid = instr_valid;
  end

  task automatic push_exp(input logic [31:0] data, input logic [31:0] addr, input logic err);
    exp_t e;
    e.instr = err ? 32'd0 : data;
    e.pc    = addr;
    e.fault = err;
    sb_q.push_back(e);
  endtask

  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data, input logic err,
                           input int rdy_dly, input bit chain);
    int n = 0;
    fetch_req = 1'b1;
    while (!imem_req_valid && n < 10) begin
      cyc();
      n++;
    end
    fetch_req = 1'b0;
    chk("req_seen", {31'd0, imem_req_valid}, 32'd1);
    chk("req_addr", imem_addr, addr);
    chk("busy_req", {31'd0, busy}, 32'd1);
    for (int i = 0; i < rdy_dly; i++) begin
      cyc();
      chk("stall_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("stall_addr", imem_addr, addr);
    end
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    chk("wait_busy", {31'd0, busy}, 32'd1);
    chk("wait_req_low", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    imem_rsp_err   = err;
    push_exp(data, addr, err);
    cyc();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    chk("hold_valid", {31'd0, instr_valid}, 32'd1);
    chk("hold_busy", {31'd0, busy}, 32'd0);
    chk("pc_next", imem_addr, addr + 32'd4);
    instr_ack = 1'b1;
    fetch_req = chain;
    cyc();
    instr_ack = 1'b0;
    chk("ack_drop", {31'd0, instr_valid}, 32'd0);
    if (chain) chk("b2b_req", {31'd0, imem_req_valid}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    fetch_req = 0; instr_ack = 0; pc_load = 0; pc_load_val = '0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0; imem_rsp_err = 0;
    #12;
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_pc", imem_addr, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // 1: immediate ready/rsp, valid three cycles after request
    fetch_one(32'h0, 32'h0000_0033, 1'b0, 0, 1'b0);
    chk("t1_pc4", imem_addr, 32'h4);
    // 2: ready stalled 5 cycles, then chained into 3
    fetch_one(32'h4, 32'h1234_5678, 1'b0, 5, 1'b1);
    // 3: error response, then clean fetch clears fault
    fetch_one(32'h8, 32'hDEAD_BEEF, 1'b1, 0, 1'b0);
    fetch_one(32'hC, 32'h0000_0013, 1'b0, 1, 1'b0);

    // 4: redirect while in WAIT, response next cycle is discarded
    fetch_req = 1'b1; cyc(); fetch_req = 1'b0;
    chk("t4_addr", imem_addr, 32'h10);
    imem_req_ready = 1'b1; cyc(); imem_req_ready = 1'b0;
    pc_load = 1'b1; pc_load_val = 32'h100; cyc(); pc_load = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0BAD_0BAD; cyc(); imem_rsp_valid = 1'b0;
    chk("t4_refetch_req", {31'd0, imem_req_valid}, 32'd1);
    chk("t4_refetch_addr", imem_addr, 32'h100);
    chk("t4_discard_instr", instr, 32'h13);
    chk("t4_discard_pc", instr_pc, 32'hC);
    imem_req_ready = 1'b1; cyc(); imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0093;
    push_exp(32'h0000_0093, 32'h100, 1'b0);
    cyc(); imem_rsp_valid = 1'b0;
    chk("t4_valid", {31'd0, instr_valid}, 32'd1);
    // redirect while holding: instruction stays valid and unchanged
    pc_load = 1'b1; pc_load_val = 32'h300; cyc(); pc_load = 1'b0;
    chk("hold_load_valid", {31'd0, instr_valid}, 32'd1);
    chk("hold_load_ipc", instr_pc, 32'h100);
    chk("hold_load_pc", imem_addr, 32'h300);
    instr_ack = 1'b1; cyc(); instr_ack = 1'b0;
    // response and redirect in the same WAIT cycle
    fetch_req = 1'b1; cyc(); fetch_req = 1'b0;
    imem_req_ready = 1'b1; cyc(); imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_1111;
    pc_load = 1'b1; pc_load_val = 32'h208;
    cyc(); imem_rsp_valid = 1'b0; pc_load = 1'b0;
    chk("same_cyc_req", {31'd0, imem_req_valid}, 32'd1);
    chk("same_cyc_addr", imem_addr, 32'h208);
    fetch_one(32'h208, 32'h2222_2222, 1'b0, 0, 1'b0);

    // 5: unaligned redirect in IDLE, then wrap at top of address space
    pc_load = 1'b1; pc_load_val = 32'h203; cyc(); pc_load = 1'b0;
    fetch_one(32'h200, 32'h0000_0513, 1'b0, 0, 1'b0);
    pc_load = 1'b1; pc_load_val = 32'hFFFF_FFFC; cyc(); pc_load = 1'b0;
    fetch_one(32'hFFFF_FFFC, 32'h0000_0073, 1'b0, 2, 1'b0);
    chk("wrap_pc", imem_addr, 32'h0);

    // 6: reset in WAIT, late response after release is ignored
    pc_load = 1'b1; pc_load_val = 32'h40; cyc(); pc_load = 1'b0;
    fetch_req = 1'b1; cyc(); fetch_req = 1'b0;
    imem_req_ready = 1'b1; cyc(); imem_req_ready = 1'b0;
    chk("t6_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_req_drop", {31'd0, imem_req_valid}, 32'd0);
    chk("t6_busy_drop", {31'd0, busy}, 32'd0);
    chk("t6_pc_reset", imem_addr, 32'h0);
    cyc();
    rst = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h3333_3333;
    cyc(); imem_rsp_valid = 1'b0;
    cyc();
    chk("t6_no_valid", {31'd0, instr_valid}, 32'd0);
    chk("t6_pc", imem_addr, 32'h0);
    chk("t6_instr", instr, 32'h0);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
